decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, parametrised instruction-field decoder for the single-cycle CPU's fetch→execute path, generalising the combinational field splitter. Adds:
- configurable instruction, opcode and datapath widths;
- optional sign extension of operand fields;
- illegal-opcode flagging;
- valid/ready handshake with a 2-entry skid buffer, so fetch and execute can stall independently at full throughput.

Parameters:
INSTR_W, 10, instruction width in bits
OPC_W, 4, opcode width; opcode = top OPC_W bits; OPR_W = INSTR_W-OPC_W, must be >=3
DATA_W, 16, width of extended operand outputs; must be >= OPR_W
SIGN_EXT, 0, 0 = zero-extend operand fields, 1 = sign-extend from field MSB
ILLEGAL_MASK, {2**OPC_W{1'b0}}, bit k set => opcode k is illegal

Ports:
Clock  in  1  rising-edge clock
ResetN  in  1  synchronous reset, active-low (sampled on Clock rising edge)
Flush  in  1  synchronous pipeline flush; drops all held and incoming instructions
InValid  in  1  Instruction is valid this cycle
InReady  out  1  stage can accept; registered
Instruction  in  INSTR_W  raw instruction word
OutValid  out  1  decoded outputs valid
OutReady  in  1  consumer accepts decoded outputs
Opcode  out  OPC_W  Instruction[INSTR_W-1:OPR_W]
FieldHi  out  DATA_W  ext(Instruction[OPR_W-1:2])
FieldMid  out  DATA_W  ext(Instruction[OPR_W-1:1])
FieldAll  out  DATA_W  ext(Instruction[OPR_W-1:0])
FieldLo  out  DATA_W  zero-extended Instruction[1:0]; never sign-extended
Bit1  out  1  Instruction[1]
Bit0  out  1  Instruction[0]
Illegal  out  1  ILLEGAL_MASK[Opcode]

Behaviour:
- Reset (ResetN=0 at edge): OutValid=0, skid empty, InReady=1, all data outputs 0. Overrides Flush and all handshakes. Any instruction in flight mid-operation is discarded.
- Field extraction and extension are computed from Instruction at accept time and registered with it. Outputs are purely registered, with no combinational path from Instruction to outputs.
- accept = InValid & InReady. give = OutValid & OutReady.
- Output register update:
  - if !OutValid or OutReady: load from skid if skid valid, else from input if accept;
  - OutValid_next = skid_valid | accept.
- Stall: if OutValid & !OutReady & accept, the instruction goes into the skid register and skid_valid becomes 1.
- Skid drain: when skid valid and the output register frees (give or !OutValid), the skid moves to the output register and skid_valid becomes 0.
- InReady_next = !skid_valid_next. The stage never accepts while the skid is occupied.
- Latency: 1 cycle from accept to OutValid. Throughput: 1 instruction/cycle with OutReady held high.
- Ordering is strictly FIFO. No instruction is dropped or duplicated except by Flush or reset.
- While OutValid & !OutReady, all outputs hold stable.
- Flush=1 at edge: OutValid=0, skid_valid=0, InReady=1.
  - An instruction accepted in the same cycle is discarded.
  - Data outputs may retain stale values; consumers must qualify them with OutValid.
- SIGN_EXT=1: replicate field MSB up to DATA_W. SIGN_EXT=0: zero-fill. FieldLo, Bit1 and Bit0 are unaffected by SIGN_EXT.
- Illegal instructions still flow through the stage normally; Illegal is informational only.

Test Plan:
- Reset: hold ResetN=0 for 2 cycles with InValid=1 -> OutValid=0, InReady=1, all outputs 0. Release reset -> first accepted word appears after 1 cycle.
- Basic decode (defaults, SIGN_EXT=0): Instruction=10'b1011011011, OutReady=1 -> next cycle Opcode=4'hB, FieldHi=16'h0006, FieldMid=16'h000D, FieldAll=16'h001B, FieldLo=16'h0003, Bit1=1, Bit0=1.
- Sign extension (SIGN_EXT=1): Instruction=10'b0001100101 -> FieldHi=16'hFFF9, FieldMid=16'hFFF2, FieldAll=16'hFFE5, FieldLo=16'h0001, Opcode=4'h1.
- Backpressure: stream 5 words A..E back-to-back, OutReady=0 for cycles 2-4 -> InReady drops the cycle after the skid fills, outputs hold A stable, then A..E emerge in order with no loss or duplication.
- Flush and illegal: ILLEGAL_MASK=16'h8000, both registers full; assert Flush with InValid=1 -> next cycle OutValid=0, InReady=1. Then send opcode 4'hF -> Illegal=1 with normal OutValid. Send opcode 4'h3 -> Illegal=0.
- Reset mid-stall: skid full, OutReady=0, pulse ResetN=0 for 1 cycle -> all state cleared. Subsequent traffic decodes correctly.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-field decoder with a valid/ready handshake.
// A 2-entry (output + skid) buffer lets fetch and execute stall independently
// while sustaining one instruction per cycle.
module decode_stage #(
  parameter int unsigned          INSTR_W      = 10,
  parameter int unsigned          OPC_W        = 4,
  parameter int unsigned          DATA_W       = 16,
  parameter int unsigned          SIGN_EXT     = 0,
  parameter logic [2**OPC_W-1:0]  ILLEGAL_MASK = '0
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                Flush,
  input  logic                InValid,
  output logic                InReady,
  input  logic [INSTR_W-1:0]  Instruction,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [OPC_W-1:0]    Opcode,
  output logic [DATA_W-1:0]   FieldHi,
  output logic [DATA_W-1:0]   FieldMid,
  output logic [DATA_W-1:0]   FieldAll,
  output logic [DATA_W-1:0]   FieldLo,
  output logic                Bit1,
  output logic                Bit0,
  output logic                Illegal
);

  localparam int unsigned OPR_W = INSTR_W - OPC_W;

  // Handshake state
  logic                out_valid_q, out_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [INSTR_W-1:0]  skid_q;

  // Registered decoded outputs
  logic [OPC_W-1:0]    opcode_q;
  logic [DATA_W-1:0]   field_hi_q, field_mid_q, field_all_q, field_lo_q;
  logic                bit1_q, bit0_q, illegal_q;

  // Control and decode signals
  logic                accept, out_free, load_out, load_skid;
  logic [INSTR_W-1:0]  src;
  logic [OPR_W-1:0]    opr;
  logic                sign;
  logic [DATA_W-1:0]   dec_hi, dec_mid, dec_all, dec_lo;

  assign accept   = InValid & in_ready_q;
  assign out_free = ~out_valid_q | OutReady;

  // The skid entry is always older than the input, so it has priority.
  assign src = skid_valid_q ? skid_q : Instruction;

  // Split and extend the operand fields of the word about to be loaded.
  always_comb begin
    opr  = src[OPR_W-1:0];
    // All three operand fields share the operand MSB as their sign bit.
    sign = (SIGN_EXT != 0) && opr[OPR_W-1];
    dec_hi               = {DATA_W{sign}};
    dec_hi[OPR_W-3:0]    = opr[OPR_W-1:2];
    dec_mid              = {DATA_W{sign}};
    dec_mid[OPR_W-2:0]   = opr[OPR_W-1:1];
    dec_all              = {DATA_W{sign}};
    dec_all[OPR_W-1:0]   = opr;
    dec_lo               = '0;
    dec_lo[1:0]          = src[1:0];
  end

  // Next-state for the output/skid occupancy and the registered ready.
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    load_out     = 1'b0;
    load_skid    = 1'b0;
    if (Flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      load_out     = skid_valid_q | accept;
      out_valid_d  = skid_valid_q | accept;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      skid_q       <= '0;
      opcode_q     <= '0;
      field_hi_q   <= '0;
      field_mid_q  <= '0;
      field_all_q  <= '0;
      field_lo_q   <= '0;
      bit1_q       <= 1'b0;
      bit0_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      if (load_skid) begin
        skid_q <= Instruction;
      end
      if (load_out) begin
        opcode_q    <= src[INSTR_W-1:OPR_W];
        field_hi_q  <= dec_hi;
        field_mid_q <= dec_mid;
        field_all_q <= dec_all;
        field_lo_q  <= dec_lo;
        bit1_q      <= src[1];
        bit0_q      <= src[0];
        illegal_q   <= ILLEGAL_MASK[src[INSTR_W-1:OPR_W]];
      end
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Opcode   = opcode_q;
  assign FieldHi  = field_hi_q;
  assign FieldMid = field_mid_q;
  assign FieldAll = field_all_q;
  assign FieldLo  = field_lo_q;
  assign Bit1     = bit1_q;
  assign Bit0     = bit0_q;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (zero-extend, and sign-extend with
// opcode F illegal) share one stimulus stream; a scoreboard per instance is
// fed on accept and drained by a monitor whenever OutValid is seen.
module tb_decode_stage;

  typedef struct packed {
    logic [3:0]  opc;
    logic [15:0] hi, mid, all, lo;
    logic        b1, b0, ill;
  } exp_t;

  logic        Clock = 1'b0;
  logic        ResetN, Flush, InValid, OutReady;
  logic [9:0]  Instruction;

  logic        InReady0, OutValid0, Bit10, Bit00, Illegal0;
  logic [3:0]  Opcode0;
  logic [15:0] FieldHi0, FieldMid0, FieldAll0, FieldLo0;
  logic        InReady1, OutValid1, Bit11, Bit01, Illegal1;
  logic [3:0]  Opcode1;
  logic [15:0] FieldHi1, FieldMid1, FieldAll1, FieldLo1;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  always #5 Clock = ~Clock;

  decode_stage dut0 (
    .Clock(Clock), .ResetN(ResetN), .Flush(Flush), .InValid(InValid), .InReady(InReady0),
    .Instruction(Instruction), .OutValid(OutValid0), .OutReady(OutReady), .Opcode(Opcode0),
    .FieldHi(FieldHi0), .FieldMid(FieldMid0), .FieldAll(FieldAll0), .FieldLo(FieldLo0),
    .Bit1(Bit10), .Bit0(Bit00), .Illegal(Illegal0)
  );

  decode_stage #(.SIGN_EXT(1), .ILLEGAL_MASK(16'h8000)) dut1 (
    .Clock(Clock), .ResetN(ResetN), .Flush(Flush), .InValid(InValid), .InReady(InReady1),
    .Instruction(Instruction), .OutValid(OutValid1), .OutReady(OutReady), .Opcode(Opcode1),
    .FieldHi(FieldHi1), .FieldMid(FieldMid1), .FieldAll(FieldAll1), .FieldLo(FieldLo1),
    .Bit1(Bit11), .Bit0(Bit01), .Illegal(Illegal1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference decode by arithmetic on the 6-bit operand.
  function automatic exp_t model(input logic [9:0] ins, input bit sext, input logic [15:0] mask);
    exp_t e;
    int   opr;
    opr   = int'(ins[5:0]);
    e.opc = ins[9:6];
    if (sext && ins[5]) begin
      e.hi  = 16'((opr >> 2) - 16);
      e.mid = 16'((opr >> 1) - 32);
      e.all = 16'(opr - 64);
    end else begin
      e.hi  = 16'(opr >> 2);
      e.mid = 16'(opr >> 1);
      e.all = 16'(opr);
    end
    e.lo  = 16'(ins[1:0]);
    e.b1  = ins[1];
    e.b0  = ins[0];
    e.ill = mask[ins[9:6]];
    return e;
  endfunction

  // One clock: drive inputs, note accepts, update scoreboards at the edge.
  task automatic step_exp(input logic v, input logic [9:0] ins, input logic ordy,
                          input logic fl, input logic rn, input exp_t e0, input exp_t e1,
                          output logic acc);
    logic a0, a1;
    InValid = v; Instruction = ins; OutReady = ordy; Flush = fl; ResetN = rn;
    @(negedge Clock);
    a0 = v & (InReady0 === 1'b1);
    a1 = v & (InReady1 === 1'b1);
    @(posedge Clock);
    if (!rn || fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (a0) q0.push_back(e0);
      if (a1) q1.push_back(e1);
    end
    #1;
    acc = a0;
  endtask

  task automatic step(input logic v, input logic [9:0] ins, input logic ordy,
                      input logic fl, input logic rn, output logic acc);
    step_exp(v, ins, ordy, fl, rn, model(ins, 1'b0, 16'h0), model(ins, 1'b1, 16'h8000), acc);
  endtask

  task automatic send(input logic [9:0] ins, input logic ordy);
    logic acc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, ins, ordy, 1'b0, 1'b1, acc);
      if (acc) return;
    end
    check("send timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 10'h0, 1'b1, 1'b0, 1'b1, acc);
  endtask

  // Monitors: compare the head while valid (checks hold-stability), pop on give.
  always @(negedge Clock) begin
    exp_t a;
    if (OutValid0 === 1'b1) begin
      a = {Opcode0, FieldHi0, FieldMid0, FieldAll0, FieldLo0, Bit10, Bit00, Illegal0};
      if (q0.size() == 0) check("dut0 unexpected output", a, 0);
      else begin
        check("dut0 decode", a, q0[0]);
        if (OutReady) void'(q0.pop_front());
      end
    end
  end

  always @(negedge Clock) begin
    exp_t a;
    if (OutValid1 === 1'b1) begin
      a = {Opcode1, FieldHi1, FieldMid1, FieldAll1, FieldLo1, Bit11, Bit01, Illegal1};
      if (q1.size() == 0) check("dut1 unexpected output", a, 0);
      else begin
        check("dut1 decode", a, q1[0]);
        if (OutReady) void'(q1.pop_front());
      end
    end
  end

  task automatic check_cleared(input string name);
    check({name, " OutValid0"}, OutValid0, 0);
    check({name, " InReady0"}, InReady0, 1);
    check({name, " OutValid1"}, OutValid1, 0);
    check({name, " InReady1"}, InReady1, 1);
  endtask

  initial begin
    logic       acc;
    logic [9:0] w [5];
    exp_t       e0, e1;
    int         idx;

    // Reset held two cycles with InValid high.
    for (int i = 0; i < 2; i++) step(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, acc);
    check_cleared("reset");
    check("reset data0", {Opcode0, FieldHi0, FieldMid0, FieldAll0, FieldLo0, Bit10, Bit00,
                          Illegal0}, 0);
    check("reset data1", {Opcode1, FieldHi1, FieldMid1, FieldAll1, FieldLo1, Bit11, Bit01,
                          Illegal1}, 0);

    // Basic decode, hand-computed; also checks 1-cycle latency.
    e0 = {4'hB, 16'h0006, 16'h000D, 16'h001B, 16'h0003, 1'b1, 1'b1, 1'b0};
    step_exp(1'b1, 10'b1011011011, 1'b1, 1'b0, 1'b1, e0, e0, acc);
    check("first accept", acc, 1);
    check("latency OutValid", OutValid0, 1);

    // Sign extension vector, hand-computed for both configurations.
    e0 = {4'h1, 16'h0009, 16'h0012, 16'h0025, 16'h0001, 1'b0, 1'b1, 1'b0};
    e1 = {4'h1, 16'hFFF9, 16'hFFF2, 16'hFFE5, 16'h0001, 1'b0, 1'b1, 1'b0};
    step_exp(1'b1, 10'b0001100101, 1'b1, 1'b0, 1'b1, e0, e1, acc);
    send(10'b1111_111111, 1'b1);
    send(10'b0110_100010, 1'b1);
    send(10'b0000_000000, 1'b1);
    idle(3);

    // Backpressure: A..E back-to-back, OutReady low in cycles 2-4.
    w[0] = 10'h2A5; w[1] = 10'h15A; w[2] = 10'h3C3; w[3] = 10'h0F0; w[4] = 10'h1E1;
    idx = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step(idx < 5, w[idx % 5], !(cyc >= 2 && cyc <= 4), 1'b0, 1'b1, acc);
      if (acc) idx++;
      if (cyc == 1) check("bp InReady after A", InReady0, 1);
      if (cyc == 2) check("bp InReady after skid fill", InReady0, 0);
      if (cyc == 4) check("bp InReady while stalled", InReady1, 0);
    end
    check("bp all accepted", idx, 5);
    check("bp drained0", q0.size(), 0);

    // Flush with both registers full and InValid high.
    send(10'h111, 1'b0);
    send(10'h222, 1'b0);
    check("full before flush", InReady0, 0);
    step(1'b1, 10'h333, 1'b0, 1'b1, 1'b1, acc);
    check_cleared("flush");
    send(10'b1111_000000, 1'b1);
    send(10'b0011_110001, 1'b1);
    idle(3);

    // Reset mid-stall with skid full.
    send(10'h155, 1'b0);
    send(10'h2AA, 1'b0);
    step(1'b1, 10'h0FF, 1'b0, 1'b0, 1'b0, acc);
    check_cleared("mid-stall reset");
    check("mid-stall reset data", {Opcode0, FieldAll0}, 0);
    send(10'b1000_101010, 1'b1);
    send(10'b0101_010101, 1'b1);
    idle(4);

    check("final drain q0", q0.size(), 0);
    check("final drain q1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
